// File: rtl/hamming74_serial_decoder.sv
// Serial Hamming(7,4) decoder: assembles MSB-first codewords, builds the syndrome
// bit by bit and corrects single-bit errors; a gap timeout drops stalled words.
module hamming74_serial_decoder #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       d_in,
    input  logic       strobe_in,
    output logic [3:0] data_out,
    output logic [6:0] code_out,
    output logic [2:0] syndrome,
    output logic       err_flag,
    output logic       valid_out,
    output logic       abort_out
);

    typedef enum logic {IDLE, RECV} state_t;

    localparam int unsigned GW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    state_t          state, state_n;
    logic [2:0]      bit_cnt, bit_cnt_n;
    logic [5:0]      shreg, shreg_n;
    logic [2:0]      syn_run, syn_n;
    logic [GW-1:0]   gap_cnt, gap_n, gap_inc;
    logic [3:0]      data_n;
    logic [6:0]      code_n;
    logic [2:0]      synd_n;
    logic            err_n, valid_n, abort_n;
    logic [2:0]      syn_add, syn_fin;
    logic [6:0]      word, flip_mask, fixed;

    // Bit arriving with count k sits at Hamming position 7-k, so the IDLE
    // capture (k=0) naturally contributes 7.
    always_comb begin
        state_n   = state;
        bit_cnt_n = bit_cnt;
        shreg_n   = shreg;
        syn_n     = syn_run;
        gap_n     = gap_cnt;
        data_n    = data_out;
        code_n    = code_out;
        synd_n    = syndrome;
        err_n     = err_flag;
        valid_n   = 1'b0;
        abort_n   = 1'b0;

        syn_add = d_in ? 3'(3'd7 - bit_cnt) : '0;
        syn_fin = syn_run ^ syn_add;
        word    = {shreg, d_in};
        for (int unsigned i = 0; i < 7; i++) begin
            flip_mask[i] = (syn_fin == 3'(i + 1));
        end
        fixed   = word ^ flip_mask;
        gap_inc = (gap_cnt == GW'(TIMEOUT)) ? gap_cnt : gap_cnt + 1'b1;

        case (state)
            IDLE: begin
                gap_n = '0;
                if (strobe_in) begin
                    shreg_n   = {shreg[4:0], d_in};
                    syn_n     = syn_fin;
                    bit_cnt_n = 3'd1;
                    state_n   = RECV;
                end
            end
            RECV: begin
                if (strobe_in) begin
                    gap_n = '0;
                    if (bit_cnt == 3'd6) begin
                        code_n    = fixed;
                        data_n    = {fixed[6], fixed[5], fixed[4], fixed[2]};
                        synd_n    = syn_fin;
                        err_n     = (syn_fin != 3'd0);
                        valid_n   = 1'b1;
                        bit_cnt_n = '0;
                        syn_n     = '0;
                        state_n   = IDLE;
                    end else begin
                        shreg_n   = {shreg[4:0], d_in};
                        syn_n     = syn_fin;
                        bit_cnt_n = bit_cnt + 3'd1;
                    end
                end else if (TIMEOUT != 0) begin
                    gap_n = gap_inc;
                    if (gap_inc == GW'(TIMEOUT)) begin
                        abort_n   = 1'b1;
                        bit_cnt_n = '0;
                        syn_n     = '0;
                        state_n   = IDLE;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            shreg     <= '0;
            syn_run   <= '0;
            gap_cnt   <= '0;
            data_out  <= '0;
            code_out  <= '0;
            syndrome  <= '0;
            err_flag  <= 1'b0;
            valid_out <= 1'b0;
            abort_out <= 1'b0;
        end else begin
            state     <= state_n;
            bit_cnt   <= bit_cnt_n;
            shreg     <= shreg_n;
            syn_run   <= syn_n;
            gap_cnt   <= gap_n;
            data_out  <= data_n;
            code_out  <= code_n;
            syndrome  <= synd_n;
            err_flag  <= err_n;
            valid_out <= valid_n;
            abort_out <= abort_n;
        end
    end

endmodule
